// File: rtl/lbp_pkg.sv
// Shared FSM type, neighbour bit positions and border helper for the raster LBP engine.
package lbp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } lbp_state_t;

    localparam int NB_TL = 0;
    localparam int NB_T  = 1;
    localparam int NB_TR = 2;
    localparam int NB_L  = 3;
    localparam int NB_R  = 4;
    localparam int NB_BL = 5;
    localparam int NB_B  = 6;
    localparam int NB_BR = 7;

    function automatic logic lbp_is_border(input int row, input int col, input int w, input int h);
        return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
    endfunction

endpackage

// File: rtl/lbp_stream_if.sv
// Gray-memory read port and LBP result write port of lbp_stream; the engine is the master.
interface lbp_stream_if #(
    parameter int DW = 8,
    parameter int AW = 14
);
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;

    modport master (
        input  gray_ready, gray_data,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, gray_data,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface

// File: rtl/lbp_line_buf.sv
// Circular delay line: dout is the sample pushed DEPTH shifts ago; one push/pop per shift.
module lbp_line_buf #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (shift) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
        end
    end

    // Storage is never reset; rows read before being written only feed border centres.
    always_ff @(posedge clk) begin
        if (shift) begin
            mem[ptr] <= din;
        end
    end

    assign dout = mem[ptr];

endmodule

// File: rtl/lbp_stream.sv
// Raster-streaming 3x3 LBP engine; define LBP_BORDER_WRITE_EN to also write border centres as 8'h00.
module lbp_stream
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8,
    parameter int AW    = 14
) (
    input  logic         clk,
    input  logic         reset,
    lbp_stream_if.master bus
);
    localparam int            NPIX       = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(NPIX - 1);
    localparam logic [AW-1:0] FILL_LEN   = AW'(IMG_W + 1);
    localparam logic [AW-1:0] FLUSH_LAST = AW'(IMG_W + 2);
    localparam logic [AW-1:0] COL_LAST   = AW'(IMG_W - 1);

    lbp_state_t    state, state_nxt;
    logic          req;
    logic [AW-1:0] addr_cnt;
    logic [AW-1:0] flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.gray_ready) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                req = 1'b1;
                if (addr_cnt == LAST_ADDR) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == FETCH && addr_cnt != LAST_ADDR) begin
                addr_cnt <= addr_cnt + AW'(1);
            end
            if (state == FLUSH) begin
                flush_cnt <= flush_cnt + AW'(1);
            end
        end
    end

    // ---- stage p0: pixel arrival, window/line-buffer update, code compute ----
    logic          vld_p0;
    logic          flush_adv;
    logic          adv_p0;
    logic [DW-1:0] pix_p0;
    logic [DW-1:0] mid_out;
    logic [DW-1:0] top_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= req;
        end
    end

    // After the last real pixel, W+1 dummy steps push the trailing centres through the window.
    assign flush_adv = (state == FLUSH) && (flush_cnt != '0) && (flush_cnt <= FILL_LEN);
    assign adv_p0    = vld_p0 || flush_adv;
    assign pix_p0    = vld_p0 ? bus.gray_data : '0;

    lbp_line_buf #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb_mid (
        .clk   (clk),
        .reset (reset),
        .shift (adv_p0),
        .din   (pix_p0),
        .dout  (mid_out)
    );

    lbp_line_buf #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb_top (
        .clk   (clk),
        .reset (reset),
        .shift (adv_p0),
        .din   (mid_out),
        .dout  (top_out)
    );

    logic [DW-1:0] win  [3][3];
    logic [DW-1:0] wnxt [3][3];

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            wnxt[r][0] = win[r][1];
            wnxt[r][1] = win[r][2];
        end
        wnxt[0][2] = top_out;
        wnxt[1][2] = mid_out;
        wnxt[2][2] = pix_p0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (adv_p0) begin
            win <= wnxt;
        end
    end

    logic [7:0] code_p0;

    always_comb begin
        code_p0        = '0;
        code_p0[NB_TL] = (wnxt[0][0] >= wnxt[1][1]);
        code_p0[NB_T]  = (wnxt[0][1] >= wnxt[1][1]);
        code_p0[NB_TR] = (wnxt[0][2] >= wnxt[1][1]);
        code_p0[NB_L]  = (wnxt[1][0] >= wnxt[1][1]);
        code_p0[NB_R]  = (wnxt[1][2] >= wnxt[1][1]);
        code_p0[NB_BL] = (wnxt[2][0] >= wnxt[1][1]);
        code_p0[NB_B]  = (wnxt[2][1] >= wnxt[1][1]);
        code_p0[NB_BR] = (wnxt[2][2] >= wnxt[1][1]);
    end

    // Centre position tracked by counters; the first W+1 arrivals only fill the window.
    logic [AW-1:0] fill_cnt;
    logic [AW-1:0] caddr;
    logic [AW-1:0] crow;
    logic [AW-1:0] ccol;
    logic          centre_p0;
    logic          border_p0;
    logic          emit_p0;

    assign centre_p0 = adv_p0 && (fill_cnt == FILL_LEN);
    assign border_p0 = lbp_is_border(int'(crow), int'(ccol), IMG_W, IMG_H);

`ifdef LBP_BORDER_WRITE_EN
    assign emit_p0 = centre_p0;
`else
    assign emit_p0 = centre_p0 && !border_p0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_cnt <= '0;
            caddr    <= '0;
            crow     <= '0;
            ccol     <= '0;
        end else begin
            if (adv_p0 && fill_cnt != FILL_LEN) begin
                fill_cnt <= fill_cnt + AW'(1);
            end
            if (centre_p0) begin
                caddr <= caddr + AW'(1);
                if (ccol == COL_LAST) begin
                    ccol <= '0;
                    crow <= crow + AW'(1);
                end else begin
                    ccol <= ccol + AW'(1);
                end
            end
        end
    end

    // ---- stage p1: registered result ----
    logic          vld_p1;
    logic [AW-1:0] addr_p1;
    logic [7:0]    data_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= emit_p0;
            if (emit_p0) begin
                addr_p1 <= caddr;
                data_p1 <= border_p0 ? 8'h00 : code_p0;
            end
        end
    end

    assign bus.gray_req  = req;
    assign bus.gray_addr = addr_cnt;
    assign bus.lbp_valid = vld_p1;
    assign bus.lbp_addr  = addr_p1;
    assign bus.lbp_data  = data_p1;
    assign bus.finish    = (state == DONE);

endmodule

// File: tb/tb_lbp_stream.sv
// Directed bench for lbp_stream: 128x128, 8x8 and 16x4 instances share one image memory model.
module tb_lbp_stream;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic go      = 1'b0;
    logic log_clr = 1'b0;
    int   sel     = 0;
    int   cur_w   = 8;
    int   cur_h   = 8;
    int   cyc     = 0;
    int   nvec    = 0;
    int   nerr    = 0;

    logic [7:0] img [16384];

    localparam int DR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    localparam int DC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
`ifdef LBP_BORDER_WRITE_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lbp_stream_if #(.DW(8), .AW(14)) b128 ();
    lbp_stream_if #(.DW(8), .AW(14)) b8 ();
    lbp_stream_if #(.DW(8), .AW(14)) b16 ();

    lbp_stream #(.IMG_W(128), .IMG_H(128), .DW(8), .AW(14)) dut128 (.clk(clk), .reset(reset), .bus(b128));
    lbp_stream #(.IMG_W(8),   .IMG_H(8),   .DW(8), .AW(14)) dut8   (.clk(clk), .reset(reset), .bus(b8));
    lbp_stream #(.IMG_W(16),  .IMG_H(4),   .DW(8), .AW(14)) dut16  (.clk(clk), .reset(reset), .bus(b16));

    assign b128.gray_ready = go && (sel == 0);
    assign b8.gray_ready   = go && (sel == 1);
    assign b16.gray_ready  = go && (sel == 2);

    always @(posedge clk) b128.gray_data <= img[b128.gray_addr];
    always @(posedge clk) b8.gray_data   <= img[b8.gray_addr];
    always @(posedge clk) b16.gray_data  <= img[b16.gray_addr];

    logic        m_req, m_valid, m_finish;
    logic [13:0] m_gaddr, m_addr;
    logic [7:0]  m_data;

    always_comb begin
        m_req    = b128.gray_req;
        m_gaddr  = b128.gray_addr;
        m_valid  = b128.lbp_valid;
        m_addr   = b128.lbp_addr;
        m_data   = b128.lbp_data;
        m_finish = b128.finish;
        if (sel == 1) begin
            m_req = b8.gray_req; m_gaddr = b8.gray_addr; m_valid = b8.lbp_valid;
            m_addr = b8.lbp_addr; m_data = b8.lbp_data; m_finish = b8.finish;
        end else if (sel == 2) begin
            m_req = b16.gray_req; m_gaddr = b16.gray_addr; m_valid = b16.lbp_valid;
            m_addr = b16.lbp_addr; m_data = b16.lbp_data; m_finish = b16.finish;
        end
    end

    logic [7:0] data_log [16384];
    int hits [16384];
    int issue_cyc [16384];
    int wr_count, first_addr, first_cyc, last_addr, last_cyc, finish_cyc, order_err, lat_err;

    always @(negedge clk) begin
        if (log_clr) begin
            for (int i = 0; i < 16384; i++) begin
                data_log[i]  <= 8'h00;
                hits[i]      <= 0;
                issue_cyc[i] <= -1;
            end
            wr_count <= 0; first_addr <= -1; first_cyc <= -1; last_addr <= -1;
            last_cyc <= -1; finish_cyc <= -1; order_err <= 0; lat_err <= 0;
        end else begin
            if (m_req) issue_cyc[m_gaddr] <= cyc;
            if (m_valid) begin
                if (wr_count == 0) begin
                    first_addr <= int'(m_addr);
                    first_cyc  <= cyc;
                end else if (int'(m_addr) <= last_addr) begin
                    order_err <= order_err + 1;
                end
                if (int'(m_addr) + cur_w + 1 < cur_w * cur_h &&
                    cyc != issue_cyc[int'(m_addr) + cur_w + 1] + 2) begin
                    lat_err <= lat_err + 1;
                end
                last_addr      <= int'(m_addr);
                last_cyc       <= cyc;
                hits[m_addr]   <= hits[m_addr] + 1;
                data_log[m_addr] <= m_data;
                wr_count       <= wr_count + 1;
            end
            if (m_finish && finish_cyc < 0) finish_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_lbp(input int w, input int h, input int a);
        int r;
        int c;
        logic [7:0] code;
        r = a / w;
        c = a % w;
        code = 8'h00;
        if (r == 0 || r == h - 1 || c == 0 || c == w - 1) return 8'h00;
        for (int i = 0; i < 8; i++) code[i] = (img[(r + DR[i]) * w + c + DC[i]] >= img[a]);
        return code;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_logs();
        #1 log_clr = 1'b1;
        @(negedge clk);
        #1 log_clr = 1'b0;
    endtask

    task automatic start(input int s, input int w, input int h, input bit rst_first);
        sel = s; cur_w = w; cur_h = h;
        if (rst_first) do_reset();
        clear_logs();
        @(negedge clk);
        chk("req_before_ready", int'(m_req), 0);
        go = 1'b1;
        @(negedge clk);
        chk("req_after_ready", int'(m_req), 1);
        chk("addr_first", int'(m_gaddr), 0);
    endtask

    task automatic finish_run(input int w, input int h);
        int n;
        n = 0;
        while (!m_finish && n < w * h + w + 64) begin
            @(negedge clk);
            n++;
        end
        chk("finish_seen", int'(m_finish), 1);
        repeat (3) @(negedge clk);
        chk("finish_sticky", int'(m_finish), 1);
        chk("req_in_done", int'(m_req), 0);
        go = 1'b0;
    endtask

    task automatic verify(input int w, input int h);
        int n, eh, herr, derr, exp_first;
        n = w * h;
        herr = 0;
        derr = 0;
        for (int a = 0; a < n; a++) begin
            eh = (EN || model_border(w, h, a) == 0) ? 1 : 0;
            if (hits[a] != eh) herr++;
            if (eh == 1 && data_log[a] != model_lbp(w, h, a)) derr++;
        end
        exp_first = EN ? 0 : w + 1;
        chk("write_count", wr_count, EN ? n : (w - 2) * (h - 2));
        chk("hit_errors", herr, 0);
        chk("data_errors", derr, 0);
        chk("addr_order_errors", order_err, 0);
        chk("latency_errors", lat_err, 0);
        chk("addr_no_stall", issue_cyc[n - 1] - issue_cyc[0], n - 1);
        chk("first_wr_addr", first_addr, exp_first);
        chk("first_wr_cycle", first_cyc, issue_cyc[exp_first + w + 1] + 2);
        chk("finish_cycle", finish_cyc, issue_cyc[n - 1] + w + 4);
        chk("last_wr_addr", last_addr, EN ? n - 1 : n - w - 2);
        chk("last_wr_cycle", last_cyc, EN ? finish_cyc - 1 : issue_cyc[n - 1] + 2);
    endtask

    function automatic int model_border(input int w, input int h, input int a);
        int r;
        int c;
        r = a / w;
        c = a % w;
        return (r == 0 || r == h - 1 || c == 0 || c == w - 1) ? 1 : 0;
    endfunction

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_gray_req", int'(b128.gray_req), 0);
        chk("rst_gray_addr", int'(b128.gray_addr), 0);
        chk("rst_lbp_valid", int'(b128.lbp_valid), 0);
        chk("rst_lbp_addr", int'(b128.lbp_addr), 0);
        chk("rst_lbp_data", int'(b128.lbp_data), 0);
        chk("rst_finish", int'(b128.finish), 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", int'({b128.gray_req, b128.lbp_valid, b128.finish,
                                      b8.gray_req, b8.lbp_valid, b8.finish,
                                      b16.gray_req, b16.lbp_valid, b16.finish}), 0);
        end

        for (int a = 0; a < 16384; a++) img[a] = 8'd50;
        start(0, 128, 128, 1'b1);
        finish_run(128, 128);
        verify(128, 128);
        chk("const_1_1", int'(data_log[129]), 8'hFF);
        chk("const_64_64", int'(data_log[8256]), 8'hFF);

        for (int a = 0; a < 64; a++) img[a] = 8'(a % 8);
        start(1, 8, 8, 1'b1);
        finish_run(8, 8);
        verify(8, 8);
        chk("ramp_1_1", int'(data_log[9]), 8'hD6);
        chk("ramp_6_6", int'(data_log[54]), 8'hD6);
        chk("ramp_3_4", int'(data_log[28]), 8'hD6);

        for (int a = 0; a < 64; a++) img[a] = 8'd10;
        img[27] = 8'd200;
        start(1, 8, 8, 1'b1);
        finish_run(8, 8);
        verify(8, 8);
        chk("spot_3_3", int'(data_log[27]), 8'h00);
        chk("spot_2_2", int'(data_log[18]), 8'hFF);
        chk("spot_4_4", int'(data_log[36]), 8'hFF);

        for (int a = 0; a < 64; a++) img[a] = 8'($urandom_range(0, 255));
        start(2, 16, 4, 1'b1);
        finish_run(16, 4);
        verify(16, 4);
        chk("wrap_r1_c0", int'(data_log[16]), 0);
        chk("wrap_r1_c15", int'(data_log[31]), 0);

        for (int a = 0; a < 16384; a++) img[a] = 8'($urandom_range(0, 255));
        start(0, 128, 128, 1'b1);
        n = 0;
        while (int'(m_gaddr) != 300 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_k300", int'(m_gaddr), 300);
        reset = 1'b1;
        #1;
        chk("midrst_gray_req", int'(b128.gray_req), 0);
        chk("midrst_gray_addr", int'(b128.gray_addr), 0);
        chk("midrst_lbp_valid", int'(b128.lbp_valid), 0);
        chk("midrst_lbp_addr", int'(b128.lbp_addr), 0);
        chk("midrst_lbp_data", int'(b128.lbp_data), 0);
        chk("midrst_finish", int'(b128.finish), 0);
        repeat (2) @(negedge clk);
        go = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", int'({b128.gray_req, b128.lbp_valid, b128.finish}), 0);
        end
        start(0, 128, 128, 1'b0);
        finish_run(128, 128);
        verify(128, 128);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
